// File: rtl/gpr_wb_arbiter_if.sv
// Writeback bus between the three GPR writeback sources and the arbiter,
// including the registered write port that feeds the GPR file.
interface gpr_wb_arbiter_if;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;

    logic        mdu_wb_valid;
    logic        mdu_wb_ready;
    logic [4:0]  mdu_wb_rd;
    logic [31:0] mdu_wb_data;

    logic        acc_wb_valid;
    logic        acc_wb_ready;
    logic [4:0]  acc_wb_rd;
    logic [31:0] acc_wb_data;

    logic        pipe_hold;
    logic        gpr_write_en;
    logic [4:0]  gpr_rd_add;
    logic [31:0] gpr_data_write;
    logic [1:0]  wb_src;

    // Requester / GPR-file side.
    modport master (
        output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        output mdu_wb_valid, mdu_wb_rd, mdu_wb_data,
        output acc_wb_valid, acc_wb_rd, acc_wb_data,
        input  mdu_wb_ready, acc_wb_ready, pipe_hold,
        input  gpr_write_en, gpr_rd_add, gpr_data_write, wb_src
    );

    // Arbiter side.
    modport slave (
        input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        input  mdu_wb_valid, mdu_wb_rd, mdu_wb_data,
        input  acc_wb_valid, acc_wb_rd, acc_wb_data,
        output mdu_wb_ready, acc_wb_ready, pipe_hold,
        output gpr_write_en, gpr_rd_add, gpr_data_write, wb_src
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: pipeline has fixed priority, MDU and ACC share the
// leftover slots round-robin with starvation protection via pipe_hold.
module gpr_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input logic              clk,
    input logic              rst,
    gpr_wb_arbiter_if.slave  wb
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_MDU  = 2'd2,
        SRC_ACC  = 2'd3
    } src_e;

    typedef enum logic {
        RR_MDU = 1'b0,
        RR_ACC = 1'b1
    } rr_e;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    rr_e              rr_q, rr_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             we_q, we_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      data_q, data_d;
    src_e             src_q, src_d;

    src_e             grant;
    logic             mdu_starve;
    logic             acc_starve;

    assign mdu_starve = wb.mdu_wb_valid && (mdu_cnt_q == LIMIT);
    assign acc_starve = wb.acc_wb_valid && (acc_cnt_q == LIMIT);

    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        grant = SRC_NONE;
        if (rst) begin
            grant = SRC_NONE;
        end else if (wb.pipe_wb_valid) begin
            grant = SRC_PIPE;
        end else if (mdu_starve ^ acc_starve) begin
            grant = mdu_starve ? SRC_MDU : SRC_ACC;
        end else if (wb.mdu_wb_valid && wb.acc_wb_valid) begin
            grant = (rr_q == RR_MDU) ? SRC_MDU : SRC_ACC;
        end else if (wb.mdu_wb_valid) begin
            grant = SRC_MDU;
        end else if (wb.acc_wb_valid) begin
            grant = SRC_ACC;
        end
    end

    assign wb.mdu_wb_ready = (grant == SRC_MDU);
    assign wb.acc_wb_ready = (grant == SRC_ACC);
    assign wb.pipe_hold    = !rst && (mdu_starve || acc_starve);

    function automatic logic [CNT_W-1:0] next_cnt(input logic             valid,
                                                  input logic             granted,
                                                  input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        nxt = '0;
        if (valid && !granted) begin
            nxt = (cnt == LIMIT) ? LIMIT : cnt + 1'b1;
        end
        return nxt;
    endfunction

    always_comb begin
        mdu_cnt_d = next_cnt(wb.mdu_wb_valid, grant == SRC_MDU, mdu_cnt_q);
        acc_cnt_d = next_cnt(wb.acc_wb_valid, grant == SRC_ACC, acc_cnt_q);

        rr_d = rr_q;
        if (grant == SRC_MDU || grant == SRC_ACC) begin
            rr_d = (rr_q == RR_MDU) ? RR_ACC : RR_MDU;
        end

        // Idle cycles keep rd/data so the GPR file inputs stay quiet.
        we_d   = 1'b0;
        src_d  = grant;
        rd_d   = rd_q;
        data_d = data_q;
        unique case (grant)
            SRC_PIPE: begin
                rd_d   = wb.pipe_wb_rd;
                data_d = wb.pipe_wb_data;
            end
            SRC_MDU: begin
                rd_d   = wb.mdu_wb_rd;
                data_d = wb.mdu_wb_data;
            end
            SRC_ACC: begin
                rd_d   = wb.acc_wb_rd;
                data_d = wb.acc_wb_data;
            end
            default: ;
        endcase
        if (grant != SRC_NONE) begin
            we_d = (rd_d != 5'd0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= RR_MDU;
            mdu_cnt_q <= '0;
            acc_cnt_q <= '0;
            we_q      <= 1'b0;
            src_q     <= SRC_NONE;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            rr_q      <= rr_d;
            mdu_cnt_q <= mdu_cnt_d;
            acc_cnt_q <= acc_cnt_d;
            we_q      <= we_d;
            src_q     <= src_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    assign wb.gpr_write_en   = we_q;
    assign wb.gpr_rd_add     = rd_q;
    assign wb.gpr_data_write = data_q;
    assign wb.wb_src         = src_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: a grant model pushes expected GPR
// writes into a queue that is popped one cycle later against the DUT.
module tb_gpr_wb_arbiter;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  src;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpr_wb_arbiter_if wb ();

    gpr_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    // Small GPR file that commits whatever the arbiter enables.
    logic [31:0] regs [32];
    always @(posedge clk) begin
        if (wb.gpr_write_en) regs[wb.gpr_rd_add] <= wb.gpr_data_write;
    end

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];

    // Reference state derived from the arbitration rules.
    logic        m_rr;     // 0 = MDU preferred, 1 = ACC preferred
    int          m_mcnt, m_acnt;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [1:0]  last_g;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 1'b0; m_mcnt = 0; m_acnt = 0; m_rd = '0; m_data = '0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        wb.pipe_wb_valid = 1'b0; wb.pipe_wb_rd = '0; wb.pipe_wb_data = '0;
        wb.mdu_wb_valid  = 1'b0; wb.mdu_wb_rd  = '0; wb.mdu_wb_data  = '0;
        wb.acc_wb_valid  = 1'b0; wb.acc_wb_rd  = '0; wb.acc_wb_data  = '0;
    endtask

    // One clock: predict and check the handshake mid-cycle, then compare the
    // registered write after the edge and retire transferred requests.
    task automatic tick();
        logic [1:0] g;
        logic       ms, as;
        wr_t        e, got;
        @(negedge clk);
        ms = wb.mdu_wb_valid && (m_mcnt == LIMIT);
        as = wb.acc_wb_valid && (m_acnt == LIMIT);
        if (wb.pipe_wb_valid)                      g = 2'd1;
        else if (ms ^ as)                          g = ms ? 2'd2 : 2'd3;
        else if (wb.mdu_wb_valid && wb.acc_wb_valid) g = m_rr ? 2'd3 : 2'd2;
        else if (wb.mdu_wb_valid)                  g = 2'd2;
        else if (wb.acc_wb_valid)                  g = 2'd3;
        else                                       g = 2'd0;
        check("mdu_ready", wb.mdu_wb_ready, g == 2'd2);
        check("acc_ready", wb.acc_wb_ready, g == 2'd3);
        check("pipe_hold", wb.pipe_hold, ms || as);

        e.we = 1'b0; e.src = g; e.rd = m_rd; e.data = m_data;
        case (g)
            2'd1: begin e.rd = wb.pipe_wb_rd; e.data = wb.pipe_wb_data; end
            2'd2: begin e.rd = wb.mdu_wb_rd;  e.data = wb.mdu_wb_data;  end
            2'd3: begin e.rd = wb.acc_wb_rd;  e.data = wb.acc_wb_data;  end
            default: ;
        endcase
        if (g != 2'd0) e.we = (e.rd != 5'd0);
        exp_q.push_back(e);
        m_rd = e.rd; m_data = e.data;

        if (g == 2'd2) m_mcnt = 0;
        else if (wb.mdu_wb_valid) m_mcnt = (m_mcnt == LIMIT) ? LIMIT : m_mcnt + 1;
        else m_mcnt = 0;
        if (g == 2'd3) m_acnt = 0;
        else if (wb.acc_wb_valid) m_acnt = (m_acnt == LIMIT) ? LIMIT : m_acnt + 1;
        else m_acnt = 0;
        if (g >= 2'd2) m_rr = ~m_rr;
        last_g = g;

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        got = '{wb.gpr_write_en, wb.gpr_rd_add, wb.gpr_data_write, wb.wb_src};
        check("gpr_we",   got.we,   e.we);
        check("wb_src",   got.src,  e.src);
        check("gpr_rd",   got.rd,   e.rd);
        check("gpr_data", got.data, e.data);
        if (g == 2'd2) wb.mdu_wb_valid = 1'b0;
        if (g == 2'd3) wb.acc_wb_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        wb.pipe_wb_valid = 1'b1; wb.mdu_wb_valid = 1'b1; wb.acc_wb_valid = 1'b1;
        #2;
        check("rst_mdu_ready", wb.mdu_wb_ready, 1'b0);
        check("rst_acc_ready", wb.acc_wb_ready, 1'b0);
        check("rst_hold",      wb.pipe_hold,    1'b0);
        check("rst_we",        wb.gpr_write_en, 1'b0);
        check("rst_rd",        wb.gpr_rd_add,   5'd0);
        check("rst_data",      wb.gpr_data_write, 32'd0);
        check("rst_src",       wb.wb_src,       2'd0);
        idle_inputs();
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] saved;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        idle_inputs();
        apply_reset();

        // Single pipe write then idle.
        wb.pipe_wb_valid = 1'b1; wb.pipe_wb_rd = 5'd5; wb.pipe_wb_data = 32'hDEADBEEF;
        tick();
        check("t1_we",   wb.gpr_write_en,   1'b1);
        check("t1_data", wb.gpr_data_write, 32'hDEADBEEF);
        wb.pipe_wb_valid = 1'b0;
        tick();
        check("t1_idle_src", wb.wb_src, 2'd0);

        // MDU and ACC together: MDU first after reset, then ACC.
        wb.mdu_wb_valid = 1'b1; wb.mdu_wb_rd = 5'd3; wb.mdu_wb_data = 32'h11;
        wb.acc_wb_valid = 1'b1; wb.acc_wb_rd = 5'd4; wb.acc_wb_data = 32'h22;
        tick();
        check("t2_src0", wb.wb_src, 2'd2);
        tick();
        check("t2_src1", wb.wb_src, 2'd3);
        tick();

        // Starvation: pipe hogs the port, MDU starves from cycle 4.
        wb.mdu_wb_valid = 1'b1; wb.mdu_wb_rd = 5'd9; wb.mdu_wb_data = 32'h99;
        for (int c = 0; c < 5; c++) begin
            wb.pipe_wb_valid = 1'b1; wb.pipe_wb_rd = 5'(10 + c); wb.pipe_wb_data = 32'(c);
            check("t3_hold", wb.pipe_hold, c >= LIMIT);
            tick();
        end
        wb.pipe_wb_valid = 1'b0;
        check("t3_hold5", wb.pipe_hold, 1'b1);
        tick();
        check("t3_mdu_win", wb.wb_src, 2'd2);
        check("t3_hold6",   wb.pipe_hold, 1'b0);
        tick();

        // x0 guard on an ACC write.
        wb.acc_wb_valid = 1'b1; wb.acc_wb_rd = 5'd0; wb.acc_wb_data = 32'hFFFFFFFF;
        tick();
        check("t4_we0",  wb.gpr_write_en, 1'b0);
        check("t4_src3", wb.wb_src, 2'd3);
        tick();
        check("t4_x0", regs[0], 32'd0);
        check("t4_r5", regs[5], 32'hDEADBEEF);

        // Hold violation: pipe keeps issuing while MDU starves.
        wb.mdu_wb_valid = 1'b1; wb.mdu_wb_rd = 5'd6; wb.mdu_wb_data = 32'h66;
        for (int c = 0; c < 8; c++) begin
            wb.pipe_wb_valid = 1'b1; wb.pipe_wb_rd = 5'd20; wb.pipe_wb_data = 32'(100 + c);
            tick();
        end
        check("t5_hold", wb.pipe_hold, 1'b1);
        wb.pipe_wb_valid = 1'b0;
        tick();
        check("t5_mdu", wb.wb_src, 2'd2);

        // Both secondaries starving: one wins, the other follows next cycle.
        wb.mdu_wb_valid = 1'b1; wb.mdu_wb_rd = 5'd7;  wb.mdu_wb_data = 32'h77;
        wb.acc_wb_valid = 1'b1; wb.acc_wb_rd = 5'd8;  wb.acc_wb_data = 32'h88;
        wb.pipe_wb_valid = 1'b1; wb.pipe_wb_rd = 5'd21; wb.pipe_wb_data = 32'h21;
        for (int c = 0; c < 6; c++) tick();
        wb.pipe_wb_valid = 1'b0;
        tick();
        check("t6_hold_persist", wb.pipe_hold, 1'b1);
        tick();
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            wb.pipe_wb_valid = ($urandom_range(0, 3) == 0);
            wb.pipe_wb_rd    = 5'($urandom);
            wb.pipe_wb_data  = $urandom;
            if (!wb.mdu_wb_valid && $urandom_range(0, 1) == 1) begin
                wb.mdu_wb_valid = 1'b1; wb.mdu_wb_rd = 5'($urandom); wb.mdu_wb_data = $urandom;
            end
            if (!wb.acc_wb_valid && $urandom_range(0, 1) == 1) begin
                wb.acc_wb_valid = 1'b1; wb.acc_wb_rd = 5'($urandom); wb.acc_wb_data = $urandom;
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // Reset while an MDU write sits in the output register.
        saved = regs[13];
        wb.mdu_wb_valid = 1'b1; wb.mdu_wb_rd = 5'd13; wb.mdu_wb_data = saved ^ 32'h5A5A_0001;
        tick();
        check("t8_pending_we", wb.gpr_write_en, 1'b1);
        rst = 1'b1;
        #1;
        check("t8_we_cleared", wb.gpr_write_en, 1'b0);
        check("t8_src_cleared", wb.wb_src, 2'd0);
        @(posedge clk);
        #1;
        check("t8_no_commit", regs[13], saved);
        #2;
        rst = 1'b0;
        model_reset();
        idle_inputs();
        // Both valid after reset: MDU must win (rr back to MDU, counters 0).
        wb.mdu_wb_valid = 1'b1; wb.mdu_wb_rd = 5'd1; wb.mdu_wb_data = 32'hA1;
        wb.acc_wb_valid = 1'b1; wb.acc_wb_rd = 5'd2; wb.acc_wb_data = 32'hA2;
        check("t8_hold", wb.pipe_hold, 1'b0);
        tick();
        check("t8_mdu_first", wb.wb_src, 2'd2);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
